// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory port, decode handshake, redirect and status.
// master = fetch controller, slave = memory/decode/branch side.
interface fetch_ctrl_if #(
    parameter int DEPTH = 4
);
    logic [63:0]            imem_addr;
    logic [31:0]            imem_instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_instr;
    logic [63:0]            out_pc;
    logic                   redirect_valid;
    logic [63:0]            redirect_pc;
    logic [$clog2(DEPTH):0] queue_count;
    logic                   fetch_fault;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redirect_valid,
        input  redirect_pc,
        output queue_count,
        output fetch_fault
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redirect_valid,
        output redirect_pc,
        input  queue_count,
        input  fetch_fault
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC owner with a DEPTH-entry prefetch queue and redirect flush.
// Optional macro FETCH_BOUND_EN stops fetch at MEM_WORDS*4 bytes and raises fetch_fault.
module fetch_ctrl #(
    parameter int          DEPTH     = 4,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_WORDS = 256
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    localparam int          PW          = $clog2(DEPTH);
    localparam int          CW          = PW + 1;
    localparam logic [63:0] BOUND_BYTES = 64'(MEM_WORDS) * 64'd4;
`ifdef FETCH_BOUND_EN
    localparam bit          BOUND_EN    = 1'b1;
`else
    localparam bit          BOUND_EN    = 1'b0;
`endif

    logic [63:0]   fetch_pc_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          fault_r;
    logic [63:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];

    logic [63:0]   target_s;
    logic          pc_oob_s;
    logic          target_oob_s;
    logic          push_s;
    logic          pop_s;

    assign target_s     = {bus.redirect_pc[63:2], 2'b00};
    // In the default build both bound flags are constant 0 and the fault logic folds away.
    assign pc_oob_s     = BOUND_EN && (fetch_pc_r >= BOUND_BYTES);
    assign target_oob_s = BOUND_EN && (target_s >= BOUND_BYTES);

    // Push/pop decision; full is judged on the registered count, redirect blocks both.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (bus.redirect_valid) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = (count_r < CW'(DEPTH)) && !pc_oob_s;
            pop_s  = (count_r != CW'(0)) && bus.out_ready;
        end
    end

    // Fetch PC, queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc_r <= target_s;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
        end else begin
            if (push_s) begin
                fetch_pc_r <= fetch_pc_r + 64'd4;
                wr_ptr_r   <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; cleared on reset so an empty head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= 64'h0;
                instr_mem_r[i] <= 32'h0;
            end
        end else if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
            instr_mem_r[wr_ptr_r] <= bus.imem_instr;
        end
    end

    // Sticky bound fault; only a redirect to an in-bound target or reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (bus.redirect_valid) begin
            fault_r <= fault_r && target_oob_s;
        end else if (pc_oob_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign bus.imem_addr   = fetch_pc_r;
    assign bus.out_valid   = (count_r != CW'(0));
    assign bus.out_instr   = instr_mem_r[rd_ptr_r];
    assign bus.out_pc      = pc_mem_r[rd_ptr_r];
    assign bus.queue_count = count_r;
    assign bus.fetch_fault = fault_r;
endmodule
